gate_alu_pipe: RTL and testbench
================================

GATE_ALU_PIPE -- requirements
Module: gate_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result bit width (legal range 1..64).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the group beat counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  input beat offered.
REQ-006 SHALL have port in_ready  output  1  block accepts the input beat this cycle.
REQ-007 SHALL have port in_a  input  WIDTH  operand A.
REQ-008 SHALL have port in_b  input  WIDTH  operand B (ignored on accumulate beats).
REQ-009 SHALL have port in_op  input  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS_A, 7 NOT_A.
REQ-010 SHALL have port in_acc  input  1  beat belongs to an accumulate group.
REQ-011 SHALL have port in_last  input  1  final beat of an accumulate group (ignored when in_acc=0).
REQ-012 SHALL have port out_valid  output  1  result held on output.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-014 SHALL have port out_data  output  WIDTH  result.
REQ-015 SHALL have port out_ones  output  clog2(WIDTH+1)  count of 1 bits in out_data.
REQ-016 SHALL have port out_zero  output  1  out_data is all zeros.
REQ-017 SHALL have port out_beats  output  CNT_W  beats contributing to out_data (1 for single beats), saturating at all-ones.
REQ-018 SHALL have port err_abort  output  1  sticky flag: an accumulate group was abandoned.

Function
REQ-019 SHALL accept a beat when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational, no skid buffer).
REQ-020 SHALL hold out_data, out_ones, out_zero, out_beats stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid on a cycle with out_ready=1 and no result produced that cycle; SHALL keep out_valid=1 on simultaneous output accept and new result.
REQ-022 SHALL compute single beats (in_acc=0) as f(in_a, in_b, in_op), bitwise, registered: result appears with out_valid one cycle after acceptance, out_beats=1.
REQ-023 SHALL maintain a two-state FSM: IDLE (no partial result) and ACCUM (partial held in internal WIDTH-bit register acc, beat count cnt).
REQ-024 IDLE, accepted beat in_acc=1, in_last=0: acc<=in_a, cnt<=1, go ACCUM, no output.
REQ-025 IDLE, accepted beat in_acc=1, in_last=1: emit in_a with out_beats=1, stay IDLE.
REQ-026 ACCUM, accepted beat in_acc=1, in_last=0: acc<=f(acc, in_a, in_op), cnt<=cnt+1 saturating, stay ACCUM, no output.
REQ-027 ACCUM, accepted beat in_acc=1, in_last=1: emit f(acc, in_a, in_op) with out_beats=cnt+1 saturating, go IDLE.
REQ-028 ACCUM, accepted beat in_acc=0: discard partial, set err_abort, process beat as single beat (REQ-022), go IDLE.
REQ-029 Operand order in accumulate SHALL be f(A=acc, B=in_a); PASS_A keeps acc, NOT_A inverts acc; in_op may change per beat.
REQ-030 out_ones and out_zero SHALL be registered with out_data, consistent in the same cycle.
REQ-031 No beat SHALL be accepted or state change while in_ready=0; in_valid without handshake SHALL have no effect.

Reset
REQ-032 On rst=1 at a rising edge: out_valid=0, out_data=0, out_ones=0, out_zero=1, out_beats=0, err_abort=0, FSM=IDLE, acc=0, cnt=0.
REQ-033 rst SHALL take priority over any simultaneous handshake; a partial group in ACCUM SHALL be dropped without setting err_abort.
REQ-034 in_ready SHALL be 1 in the first cycle after reset release.

Verification (WIDTH=8, CNT_W=8)
REQ-035 Single beats, out_ready=1: a=0xF0,b=0xCC, op 0..7 -> out_data 0xC0,0xFC,0x3C,0x3F,0x03,0xC3,0xF0,0x0F one cycle later; out_ones 2,6,4,6,2,4,4,4.
REQ-036 Backpressure: out_ready=0, AND 0xFF&0x01 accepted -> out_valid=1, in_ready=0, out_data=0x01 held 5 cycles; out_ready=1 -> next beat accepted same cycle.
REQ-037 Accumulate XOR: beats a=0x01,0x02,0x04 (last on 3rd) -> single output 0x07, out_beats=3, out_ones=3; no output on beats 1-2.
REQ-038 Abort: acc beats 0xAA,0x55 then in_acc=0 AND 0x0F&0xFF -> output 0x0F, out_beats=1, err_abort=1 until reset.
REQ-039 Reset mid-group: two acc beats then rst=1 -> all outputs per REQ-032; next group a=0x80 last -> 0x80, out_beats=1, err_abort=0.
REQ-040 Saturation: 300 acc OR beats of 0x00 then last 0x01 -> out_data=0x01, out_beats=0xFF, out_zero=0.

Source files
------------

// File: rtl/gate_alu_pipe.sv
// Bitwise gate ALU with a one-deep registered output stage and an accumulate mode
// that folds a group of beats into a single result.
module gate_alu_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic [2:0]                   in_op,
    input  logic                         in_acc,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(WIDTH+1)-1:0]   out_ones,
    output logic                         out_zero,
    output logic [CNT_W-1:0]             out_beats,
    output logic                         err_abort
);
    localparam int unsigned ONES_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               emit;
    logic [WIDTH-1:0]   emit_data;
    logic [CNT_W-1:0]   emit_beats;
    logic [WIDTH-1:0]   acc_res;
    logic [CNT_W-1:0]   cnt_inc;

    function automatic logic [WIDTH-1:0] gate_op(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0] op);
        logic [WIDTH-1:0] r;
        unique case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~(a & b);
            3'd4: r = ~(a | b);
            3'd5: r = ~(a ^ b);
            3'd6: r = a;
            3'd7: r = ~a;
        endcase
        return r;
    endfunction

    function automatic logic [ONES_W-1:0] popcount(input logic [WIDTH-1:0] d);
        logic [ONES_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            n = n + ONES_W'(d[i]);
        end
        return n;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign acc_res  = gate_op(acc_q, in_a, in_op);

    always_comb begin
        emit       = 1'b0;
        emit_data  = gate_op(in_a, in_b, in_op);
        emit_beats = CNT_W'(1);
        if (accept) begin
            if (!in_acc) begin
                emit = 1'b1;
            end else if (state_q == StIdle) begin
                // A one-beat group is just its operand.
                emit      = in_last;
                emit_data = in_a;
            end else begin
                emit       = in_last;
                emit_data  = acc_res;
                emit_beats = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ones  <= '0;
            out_zero  <= 1'b1;
            out_beats <= '0;
            err_abort <= 1'b0;
        end else begin
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= emit_data;
                out_ones  <= popcount(emit_data);
                out_zero  <= (emit_data == '0);
                out_beats <= emit_beats;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                if (!in_acc) begin
                    // A single beat arriving mid-group abandons the partial result.
                    if (state_q == StAccum) begin
                        err_abort <= 1'b1;
                    end
                    state_q <= StIdle;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                end else if (state_q == StIdle) begin
                    if (!in_last) begin
                        state_q <= StAccum;
                        acc_q   <= in_a;
                        cnt_q   <= CNT_W'(1);
                    end
                end else if (in_last) begin
                    state_q <= StIdle;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                end else begin
                    acc_q <= acc_res;
                    cnt_q <= cnt_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_gate_alu_pipe.sv
// Bench for gate_alu_pipe: table-driven single beats plus directed accumulate,
// backpressure, abort, reset and saturation sequences, checked through a scoreboard.
module tb_gate_alu_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       in_acc;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_ones;
    logic       out_zero;
    logic [7:0] out_beats;
    logic       err_abort;

    typedef struct {
        logic [7:0] data;
        logic [3:0] ones;
        logic       zero;
        logic [7:0] beats;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] d;
        logic [3:0] ones;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   n_cmp = 0;
    int   n_bad = 0;

    gate_alu_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ones  (out_ones),
        .out_zero  (out_zero),
        .out_beats (out_beats),
        .err_abort (err_abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [3:0] ones, input logic [7:0] beats);
        exp_t e;
        e.data  = d;
        e.ones  = ones;
        e.zero  = (d == 8'h00);
        e.beats = beats;
        sb.push_back(e);
    endtask

    // Offer one beat and return at posedge+1 after it has been accepted.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic acc, input logic last);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_acc   = acc;
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard: compare each result on the cycle it is handed downstream.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_ones", out_ones, e.ones);
                check("out_zero", out_zero, e.zero);
                check("out_beats", out_beats, e.beats);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_ones"}, out_ones, 0);
        check({tag, "_out_zero"}, out_zero, 1);
        check({tag, "_out_beats"}, out_beats, 0);
        check({tag, "_err_abort"}, err_abort, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{8'hF0, 8'hCC, 3'd0, 8'hC0, 4'd2};
        vecs[1]  = '{8'hF0, 8'hCC, 3'd1, 8'hFC, 4'd6};
        vecs[2]  = '{8'hF0, 8'hCC, 3'd2, 8'h3C, 4'd4};
        vecs[3]  = '{8'hF0, 8'hCC, 3'd3, 8'h3F, 4'd6};
        vecs[4]  = '{8'hF0, 8'hCC, 3'd4, 8'h03, 4'd2};
        vecs[5]  = '{8'hF0, 8'hCC, 3'd5, 8'hC3, 4'd4};
        vecs[6]  = '{8'hF0, 8'hCC, 3'd6, 8'hF0, 4'd4};
        vecs[7]  = '{8'hF0, 8'hCC, 3'd7, 8'h0F, 4'd4};
        vecs[8]  = '{8'h0F, 8'hF0, 3'd0, 8'h00, 4'd0};
        vecs[9]  = '{8'hAA, 8'h55, 3'd5, 8'h00, 4'd0};
        vecs[10] = '{8'h00, 8'h12, 3'd7, 8'hFF, 4'd8};

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        in_acc = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // Single beats, back to back, downstream always ready.
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            push(vecs[i].d, vecs[i].ones, 8'd1);
            send(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: hold result, refuse a pending beat, then accept it same cycle.
        out_ready = 1'b0;
        push(8'h01, 4'd1, 8'd1);
        send(8'hFF, 8'h01, 3'd0, 1'b0, 1'b0);
        push(8'h30, 4'd2, 8'd1);
        in_valid = 1'b1;
        in_a = 8'h10;
        in_b = 8'h20;
        in_op = 3'd1;
        in_acc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_data_held", out_data, 8'h01);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_back_to_back_valid", out_valid, 1);
        @(posedge clk);
        #1;

        // Accumulate XOR of three beats.
        send(8'h01, 8'h00, 3'd2, 1'b1, 1'b0);
        send(8'h02, 8'h00, 3'd2, 1'b1, 1'b0);
        push(8'h07, 4'd3, 8'd3);
        send(8'h04, 8'h00, 3'd2, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Abort: single beat interrupts an open group.
        @(negedge clk);
        check("abort_before", err_abort, 0);
        @(posedge clk);
        #1;
        send(8'hAA, 8'h00, 3'd2, 1'b1, 1'b0);
        send(8'h55, 8'h00, 3'd2, 1'b1, 1'b0);
        push(8'h0F, 4'd4, 8'd1);
        send(8'h0F, 8'hFF, 3'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_sticky", err_abort, 1);
        @(posedge clk);
        #1;

        // Reset in the middle of a group drops the partial without an abort.
        send(8'h11, 8'h00, 3'd1, 1'b1, 1'b0);
        send(8'h22, 8'h00, 3'd1, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        push(8'h80, 4'd1, 8'd1);
        send(8'h80, 8'h00, 3'd1, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_no_abort", err_abort, 0);
        @(posedge clk);
        #1;

        // Beat counter saturation.
        for (int i = 0; i < 300; i++) begin
            send(8'h00, 8'h00, 3'd1, 1'b1, 1'b0);
        end
        push(8'h01, 4'd1, 8'hFF);
        send(8'h01, 8'h00, 3'd1, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
